// File: rtl/branch_resolve_queue.sv
// In-order branch metadata FIFO: fetch enqueues, execute pops/compares (ED_* same cycle, MD_* one cycle later).
// No internal backpressure: full_o tells fetch to stall, enqueues into a full queue without a pop are dropped and flagged.
module branch_resolve_queue #(
  parameter int HIST_W = 7,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              F_enq_valid_i,
  input  logic [HIST_W-1:0] F_PC_i,
  input  logic [HIST_W-1:0] F_global_history_i,
  input  logic              F_global_predict_i,
  input  logic              F_local_predict_i,
  input  logic              F_final_predict_i,
  output logic              full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic              ovf_o,
  input  logic              E_resolve_valid_i,
  input  logic              E_actual_taken_i,
  input  logic              flush_i,
  output logic              E_mispredict_o,
  output logic              ED_train_valid_o,
  output logic [HIST_W-1:0] ED_train_global_history_o,
  output logic              ED_train_global_predict_o,
  output logic              ED_train_global_taken_o,
  output logic              MD_train_valid_o,
  output logic [HIST_W-1:0] MD_PC_o,
  output logic [HIST_W-1:0] MD_train_global_history_o,
  output logic              MD_train_predict_o,
  output logic              MD_train_taken_o,
  output logic              MD_train_global_predict_o,
  output logic              MD_train_local_predict_o,
  output logic              MD_train_global_taken_o,
  output logic              MD_train_local_taken_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [HIST_W-1:0] pc;
    logic [HIST_W-1:0] hist;
    logic              gp;
    logic              lp;
    logic              fp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic              md_vld_q, md_vld_d;
  logic [HIST_W-1:0] md_pc_q, md_pc_d, md_hist_q, md_hist_d;
  logic              md_fp_q, md_fp_d, md_taken_q, md_taken_d;
  logic              md_gp_q, md_gp_d, md_lp_q, md_lp_d;
  logic              md_gtaken_q, md_gtaken_d, md_ltaken_q, md_ltaken_d;

  entry_t head;
  entry_t new_entry;
  logic   full, pop, mispredict, kill, enq_ok;

  assign head       = mem_q[head_q];
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = E_resolve_valid_i & (count_q != '0);
  assign mispredict = pop & (head.fp != E_actual_taken_i);
  assign kill       = mispredict | flush_i;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign enq_ok     = F_enq_valid_i & (~full | pop) & ~kill;

  assign new_entry = '{pc: F_PC_i, hist: F_global_history_i, gp: F_global_predict_i,
                       lp: F_local_predict_i, fp: F_final_predict_i};

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(enq_ok) - CW'(pop);
    ovf_d   = ovf_q | (F_enq_valid_i & full & ~pop);
    if (enq_ok) begin
      mem_d[tail_q] = new_entry;
      tail_d        = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    // Everything younger than the resolved head is wrong-path.
    if (kill) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_comb begin
    md_vld_d    = pop;
    md_pc_d     = md_pc_q;
    md_hist_d   = md_hist_q;
    md_fp_d     = md_fp_q;
    md_taken_d  = md_taken_q;
    md_gp_d     = md_gp_q;
    md_lp_d     = md_lp_q;
    md_gtaken_d = md_gtaken_q;
    md_ltaken_d = md_ltaken_q;
    if (pop) begin
      md_pc_d     = head.pc;
      md_hist_d   = head.hist;
      md_fp_d     = head.fp;
      md_taken_d  = (head.fp == E_actual_taken_i);
      md_gp_d     = head.gp;
      md_lp_d     = head.lp;
      md_gtaken_d = (head.gp == E_actual_taken_i);
      md_ltaken_d = (head.lp == E_actual_taken_i);
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      md_vld_q    <= 1'b0;
      md_pc_q     <= '0;
      md_hist_q   <= '0;
      md_fp_q     <= 1'b0;
      md_taken_q  <= 1'b0;
      md_gp_q     <= 1'b0;
      md_lp_q     <= 1'b0;
      md_gtaken_q <= 1'b0;
      md_ltaken_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      md_vld_q    <= md_vld_d;
      md_pc_q     <= md_pc_d;
      md_hist_q   <= md_hist_d;
      md_fp_q     <= md_fp_d;
      md_taken_q  <= md_taken_d;
      md_gp_q     <= md_gp_d;
      md_lp_q     <= md_lp_d;
      md_gtaken_q <= md_gtaken_d;
      md_ltaken_q <= md_ltaken_d;
    end
  end

  assign full_o                    = full;
  assign count_o                   = count_q;
  assign ovf_o                     = ovf_q;
  assign E_mispredict_o            = mispredict;
  assign ED_train_valid_o          = pop;
  assign ED_train_global_history_o = pop ? head.hist : '0;
  assign ED_train_global_predict_o = pop & head.gp;
  assign ED_train_global_taken_o   = pop & (head.gp == E_actual_taken_i);

  assign MD_train_valid_o          = md_vld_q;
  assign MD_PC_o                   = md_pc_q;
  assign MD_train_global_history_o = md_hist_q;
  assign MD_train_predict_o        = md_fp_q;
  assign MD_train_taken_o          = md_taken_q;
  assign MD_train_global_predict_o = md_gp_q;
  assign MD_train_local_predict_o  = md_lp_q;
  assign MD_train_global_taken_o   = md_gtaken_q;
  assign MD_train_local_taken_o    = md_ltaken_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed and random stimulus for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int HW = 7;
  localparam int D  = 8;

  logic          clk_i = 1'b0;
  logic          rst;
  logic          F_enq_valid_i;
  logic [HW-1:0] F_PC_i, F_global_history_i;
  logic          F_global_predict_i, F_local_predict_i, F_final_predict_i;
  logic          full_o, ovf_o;
  logic [3:0]    count_o;
  logic          E_resolve_valid_i, E_actual_taken_i, flush_i;
  logic          E_mispredict_o, ED_train_valid_o;
  logic [HW-1:0] ED_train_global_history_o;
  logic          ED_train_global_predict_o, ED_train_global_taken_o;
  logic          MD_train_valid_o;
  logic [HW-1:0] MD_PC_o, MD_train_global_history_o;
  logic          MD_train_predict_o, MD_train_taken_o;
  logic          MD_train_global_predict_o, MD_train_local_predict_o;
  logic          MD_train_global_taken_o, MD_train_local_taken_o;

  branch_resolve_queue #(.HIST_W(HW), .DEPTH(D)) dut (
    .clk_i(clk_i), .rst(rst),
    .F_enq_valid_i(F_enq_valid_i), .F_PC_i(F_PC_i), .F_global_history_i(F_global_history_i),
    .F_global_predict_i(F_global_predict_i), .F_local_predict_i(F_local_predict_i),
    .F_final_predict_i(F_final_predict_i),
    .full_o(full_o), .count_o(count_o), .ovf_o(ovf_o),
    .E_resolve_valid_i(E_resolve_valid_i), .E_actual_taken_i(E_actual_taken_i), .flush_i(flush_i),
    .E_mispredict_o(E_mispredict_o), .ED_train_valid_o(ED_train_valid_o),
    .ED_train_global_history_o(ED_train_global_history_o),
    .ED_train_global_predict_o(ED_train_global_predict_o),
    .ED_train_global_taken_o(ED_train_global_taken_o),
    .MD_train_valid_o(MD_train_valid_o), .MD_PC_o(MD_PC_o),
    .MD_train_global_history_o(MD_train_global_history_o),
    .MD_train_predict_o(MD_train_predict_o), .MD_train_taken_o(MD_train_taken_o),
    .MD_train_global_predict_o(MD_train_global_predict_o),
    .MD_train_local_predict_o(MD_train_local_predict_o),
    .MD_train_global_taken_o(MD_train_global_taken_o),
    .MD_train_local_taken_o(MD_train_local_taken_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [HW-1:0] pc;
    logic [HW-1:0] hist;
    logic          gp;
    logic          lp;
    logic          fp;
  } ent_t;

  ent_t          mq[$];
  logic          m_ovf;
  logic          e_vld, e_fp, e_tk, e_gp, e_lp, e_gtk, e_ltk;
  logic [HW-1:0] e_pc, e_hist;
  logic [HW-1:0] md_log[$];
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_md();
    check_val("md_valid",  MD_train_valid_o, e_vld);
    check_val("md_pc",     MD_PC_o, e_pc);
    check_val("md_hist",   MD_train_global_history_o, e_hist);
    check_val("md_pred",   MD_train_predict_o, e_fp);
    check_val("md_taken",  MD_train_taken_o, e_tk);
    check_val("md_gp",     MD_train_global_predict_o, e_gp);
    check_val("md_lp",     MD_train_local_predict_o, e_lp);
    check_val("md_gtaken", MD_train_global_taken_o, e_gtk);
    check_val("md_ltaken", MD_train_local_taken_o, e_ltk);
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input logic enq, input logic [HW-1:0] pc, input logic [HW-1:0] hist,
                      input logic gp, input logic lp, input logic fp,
                      input logic res, input logic act, input logic fl);
    logic pop, kill;
    ent_t h, n;
    int   sz;
    F_enq_valid_i = enq; F_PC_i = pc; F_global_history_i = hist;
    F_global_predict_i = gp; F_local_predict_i = lp; F_final_predict_i = fp;
    E_resolve_valid_i = res; E_actual_taken_i = act; flush_i = fl;
    #1;
    sz  = mq.size();
    pop = res && (sz != 0);
    h   = pop ? mq[0] : '0;
    check_val("count",      count_o, sz);
    check_val("full",       full_o, sz == D);
    check_val("ovf",        ovf_o, m_ovf);
    check_val("ed_valid",   ED_train_valid_o, pop);
    check_val("ed_hist",    ED_train_global_history_o, h.hist);
    check_val("ed_gp",      ED_train_global_predict_o, h.gp);
    check_val("ed_gtaken",  ED_train_global_taken_o, pop && (h.gp == act));
    check_val("mispredict", E_mispredict_o, pop && (h.fp != act));
    kill = (pop && (h.fp != act)) || fl;
    @(posedge clk_i);
    e_vld = pop;
    if (pop) begin
      e_pc = h.pc; e_hist = h.hist; e_fp = h.fp; e_gp = h.gp; e_lp = h.lp;
      e_tk = (h.fp == act); e_gtk = (h.gp == act); e_ltk = (h.lp == act);
      void'(mq.pop_front());
    end
    if (enq && sz == D && !pop) m_ovf = 1'b1;
    if (kill) mq.delete();
    else if (enq && (sz < D || pop)) begin
      n.pc = pc; n.hist = hist; n.gp = gp; n.lp = lp; n.fp = fp;
      mq.push_back(n);
    end
    @(negedge clk_i);
    #1;
    check_md();
    if (MD_train_valid_o) md_log.push_back(MD_PC_o);
  endtask

  // Reset is held while enqueue and resolve are both requested; it must win.
  task automatic do_reset();
    rst = 1'b1;
    F_enq_valid_i = 1'b1; E_resolve_valid_i = 1'b1; E_actual_taken_i = 1'b0; flush_i = 1'b0;
    F_PC_i = 7'h7f; F_global_history_i = 7'h7f;
    F_global_predict_i = 1'b1; F_local_predict_i = 1'b1; F_final_predict_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    mq.delete();
    m_ovf = 1'b0;
    {e_vld, e_fp, e_tk, e_gp, e_lp, e_gtk, e_ltk} = '0;
    e_pc = '0; e_hist = '0;
    check_val("rst_count",    count_o, 0);
    check_val("rst_ovf",      ovf_o, 0);
    check_val("rst_full",     full_o, 0);
    check_val("rst_ed_valid", ED_train_valid_o, 0);
    check_val("rst_mispred",  E_mispredict_o, 0);
    check_md();
    rst = 1'b0;
    F_enq_valid_i = 1'b0; E_resolve_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    F_enq_valid_i = 1'b0; F_PC_i = '0; F_global_history_i = '0;
    F_global_predict_i = 1'b0; F_local_predict_i = 1'b0; F_final_predict_i = 1'b0;
    E_resolve_valid_i = 1'b0; E_actual_taken_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Single branch, correctly predicted by global and final, wrong by local.
    step(1, 7'h05, 7'h12, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check_val("first_md_pc", MD_PC_o, 7'h05);
    check_val("first_md_taken", MD_train_taken_o, 1);
    check_val("first_md_ltaken", MD_train_local_taken_o, 0);

    // Fill, overflow, then enq+resolve while full.
    for (int i = 0; i < D; i++) step(1, 7'(i + 32), 7'(i), 0, 1, 1, 0, 0, 0);
    step(1, 7'h55, 7'h55, 0, 0, 1, 0, 0, 0);
    check_val("ovf_set", ovf_o, 1);
    step(1, 7'h56, 7'h56, 1, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("full_count", count_o, D);
    do_reset();

    // Mispredict on A kills B and C; A still trains.
    step(1, 7'h0a, 7'h01, 1, 1, 0, 0, 0, 0);
    step(1, 7'h0b, 7'h02, 0, 0, 1, 0, 0, 0);
    step(1, 7'h0c, 7'h03, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check_val("kill_count", count_o, 0);
    check_val("kill_md_pc", MD_PC_o, 7'h0a);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Pointer wrap: 20 branches in flight one at a time.
    md_log.delete();
    for (int i = 0; i < 20; i++)
      step(1, 7'(i), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1, (i > 0), 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check_val("wrap_len", md_log.size(), 20);
    for (int i = 0; i < 20 && i < md_log.size(); i++) check_val("wrap_pc", md_log[i], i);

    // Flush with three entries and a same-cycle enqueue.
    for (int i = 0; i < 3; i++) step(1, 7'(i + 64), 7'(i), 0, 0, 0, 0, 0, 0);
    step(1, 7'h70, 7'h70, 0, 0, 0, 0, 0, 1);
    check_val("flush_count", count_o, 0);
    check_val("flush_md_valid", MD_train_valid_o, 0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) step(1, 7'(i + 80), 7'(i), 1, 1, 1, (i > 1), 1, 0);
    do_reset();

    // Random traffic; resolves usually agree with the head's final prediction.
    for (int n = 0; n < 600; n++) begin
      logic a;
      if (n % 200 == 199) do_reset();
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) a = mq[0].fp;
      else a = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 2) != 0), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), a, 1'($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
